// File: rtl/ex_muldiv_unit_pkg.sv
// Shared types and constants for the RV32M execute unit (M-extension additions).
// Optional build macro used by the unit: MULDIV_FAST_MUL_EN.
package ex_muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/ex_muldiv_unit_div_iter_core.sv
// Restoring divider datapath: one quotient bit per enabled cycle on unsigned magnitudes.
module div_iter_core
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quo_next,
  output logic [WIDTH-1:0] rem_next
);

  logic [WIDTH-1:0] rem_q, quo_q, dsr_q;
  logic [WIDTH:0]   shifted, diff;
  logic             fits;

  // The step result is exposed so the last iteration can be committed on its own edge.
  always_comb begin
    shifted  = {rem_q, quo_q[WIDTH-1]};
    diff     = shifted - {1'b0, dsr_q};
    fits     = ~diff[WIDTH];
    rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_next = {quo_q[WIDTH-2:0], fits};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (en) begin
      rem_q <= rem_next;
      quo_q <= quo_next;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Execute-stage RV32M multiply/divide unit with pipeline stall request.
// Define MULDIV_FAST_MUL_EN for single-cycle multiplies; default build iterates.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = XLEN,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e    state;
  muldiv_op_e       op_in, op_q;
  logic             sign_q, sign_r;
  logic [CNT_W-1:0] cnt;
  logic             a_sgn, b_sgn, a_neg, b_neg, is_div, div_zero, div_ovf, special;
  logic             accept, last_iter;
  logic [WIDTH-1:0] mag_a, mag_b, special_res, q_nx, r_nx, div_res;

  always_comb begin
    op_in = muldiv_op_e'(funct3);
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (op_in)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        a_sgn = 1'b1;
        b_sgn = 1'b1;
      end
      MD_MULHSU: a_sgn = 1'b1;
      default: ;
    endcase
  end

  assign a_neg    = a_sgn & op_a[WIDTH-1];
  assign b_neg    = b_sgn & op_b[WIDTH-1];
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b    = b_neg ? -op_b : op_b;
  assign is_div   = funct3[2];
  assign div_zero = is_div && (op_b == '0);
  assign div_ovf  = (op_in == MD_DIV || op_in == MD_REM) && (op_a == MIN_NEG) && (op_b == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_zero)     special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : MIN_NEG;
  end

  assign accept    = (state == ST_IDLE) && start && !flush;
  assign stall_req = !rst && (accept || state == ST_MUL || state == ST_DIV);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  div_iter_core #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && is_div && !special),
    .en       (state == ST_DIV),
    .dividend (mag_a),
    .divisor  (mag_b),
    .quo_next (q_nx),
    .rem_next (r_nx)
  );

  // Quotient takes sign(a)^sign(b), remainder takes sign(a).
  assign div_res = op_q[1] ? (sign_r ? -r_nx : r_nx) : (sign_q ? -q_nx : q_nx);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [WIDTH:0]     fa, fb;
  logic signed [2*WIDTH+1:0] fp;
  logic [WIDTH-1:0]          fast_res;

  always_comb begin
    fa       = {a_sgn & op_a[WIDTH-1], op_a};
    fb       = {b_sgn & op_b[WIDTH-1], op_b};
    fp       = fa * fb;
    fast_res = (op_in == MD_MUL) ? fp[WIDTH-1:0] : fp[2*WIDTH-1:WIDTH];
  end
`else
  logic [WIDTH-1:0]   mcand, mul_res;
  logic [2*WIDTH-1:0] prod, prod_nx, prod_fix;
  logic [WIDTH:0]     psum;

  // Multiplier sits in the low half of prod and is consumed as partial sums shift in.
  always_comb begin
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nx  = {psum, prod[WIDTH-1:1]};
    prod_fix = sign_q ? -prod_nx : prod_nx;
    mul_res  = (op_q == MD_MUL) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cnt    <= '0;
      op_q   <= MD_MUL;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      mcand  <= '0;
      prod   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            op_q   <= op_in;
            sign_q <= a_neg ^ b_neg;
            sign_r <= a_neg;
            cnt    <= '0;
            if (special) begin
              result <= special_res;
              state  <= ST_DONE;
              done   <= 1'b1;
            end else if (!is_div) begin
`ifdef MULDIV_FAST_MUL_EN
              result <= fast_res;
              state  <= ST_DONE;
              done   <= 1'b1;
`else
              mcand  <= mag_a;
              prod   <= {{WIDTH{1'b0}}, mag_b};
              state  <= ST_MUL;
              busy   <= 1'b1;
`endif
            end else begin
              state <= ST_DIV;
              busy  <= 1'b1;
            end
          end
`ifndef MULDIV_FAST_MUL_EN
          ST_MUL: begin
            prod <= prod_nx;
            cnt  <= cnt + 1'b1;
            if (last_iter) begin
              result <= mul_res;
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
`endif
          ST_DIV: begin
            cnt <= cnt + 1'b1;
            if (last_iter) begin
              result <= div_res;
              state  <= ST_DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (default iterative-multiply build).
module tb_ex_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk, rst, flush, start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, result;
  logic        stall_req, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  ex_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the unit idle; returns at a negedge back in IDLE.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int stalls);
    bit got = 0;
    funct3 = f3; op_a = a; op_b = b; start = 1'b1;
    stalls = 0;
    res    = 'x;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done) begin
        res = result;
        got = 1;
        break;
      end
      if (stall_req) stalls++;
      @(negedge clk);
    end
    start = 1'b0;
    check("op_done_seen", 32'(got), 32'd1);
    @(negedge clk);
  endtask

  logic [31:0] r;
  int          st;

  initial begin
    rst = 1'b1; flush = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   32'(busy),      32'd0);
    check("rst_done",   32'(done),      32'd0);
    check("rst_result", result,         32'd0);
    check("rst_stall",  32'(stall_req), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(F_MUL, 32'd7, -32'sd3, r, st);
    check("mul_res",   r, 32'hFFFF_FFEB);
    check("mul_stall", 32'(st), 32'(MUL_STALL));
    run_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, st);
    check("mulhu_res", r, 32'hFFFF_FFFE);
    run_op(F_MULH, 32'h8000_0000, 32'd2, r, st);
    check("mulh_res", r, 32'hFFFF_FFFF);

    run_op(F_DIV, -32'sd20, 32'd3, r, st);
    check("div_res",   r, 32'hFFFF_FFFA);
    check("div_stall", 32'(st), 32'd33);
    run_op(F_REM, -32'sd20, 32'd3, r, st);
    check("rem_res", r, 32'hFFFF_FFFE);

    run_op(F_DIVU, 32'd100, 32'd0, r, st);
    check("divu0_res",   r, 32'hFFFF_FFFF);
    check("divu0_stall", 32'(st), 32'd1);
    run_op(F_REM, 32'd100, 32'd0, r, st);
    check("rem0_res", r, 32'd100);

    // flush beats start in IDLE
    funct3 = F_DIV; op_a = 32'd50; op_b = 32'd7; start = 1'b1; flush = 1'b1;
    #1 check("flushidle_stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    check("flushidle_busy", 32'(busy), 32'd0);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);

    // flush mid-divide at iteration 10
    funct3 = F_DIV; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
    repeat (11) @(negedge clk);
    check("flush_pre_busy", 32'(busy), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    check("flush_busy",  32'(busy),      32'd0);
    check("flush_stall", 32'(stall_req), 32'd0);
    begin
      int pulses = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        #1 if (done) pulses++;
      end
      check("flush_no_done", 32'(pulses), 32'd0);
    end
    check("flush_result_held", result, 32'd100);
    @(negedge clk);
    run_op(F_DIVU, 32'd9, 32'd2, r, st);
    check("after_flush_divu", r, 32'd4);

    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, st);
    check("ovf_div_res",   r, 32'h8000_0000);
    check("ovf_div_stall", 32'(st), 32'd1);
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, st);
    check("ovf_rem_res", r, 32'd0);

    // asynchronous reset during iteration 5
    funct3 = F_DIV; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_pre_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy",  32'(busy),      32'd0);
    check("midrst_stall", 32'(stall_req), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op(F_DIVU, 32'd9, 32'd2, r, st);
    check("after_rst_divu", r, 32'd4);

    // back-to-back divides with start held through DONE
    begin
      int pulses = 0;
      int t_first = 0;
      int t_second = 0;
      logic [31:0] r1 = '0, r2 = '0;
      funct3 = F_DIV; op_a = -32'sd20; op_b = 32'd3; start = 1'b1;
      for (int i = 0; i < 120; i++) begin
        #1;
        if (done) begin
          pulses++;
          if (pulses == 1) begin
            r1 = result; t_first = i;
            op_a = 32'd50; op_b = 32'd7;
          end else begin
            r2 = result; t_second = i;
            start = 1'b0;
          end
        end
        @(negedge clk);
      end
      start = 1'b0;
      check("b2b_pulses", 32'(pulses), 32'd2);
      check("b2b_res1",   r1, 32'hFFFF_FFFA);
      check("b2b_res2",   r2, 32'd7);
      check("b2b_gap",    32'(t_second - t_first), 32'd34);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
